// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one quotient bit per clock.
// Produces Q and R with Q*B + R == A, plus a one-cycle done pulse. A zero
// divisor skips the iterations and reports Q = all ones, R = A, div0 = 1.
module divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    // ZERO is a one-cycle hold on the divide-by-zero path so that done lands
    // one clock after the accepted start instead of on the start edge itself.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZERO,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             last;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor,
    // keep the difference only when no borrow appears in the top bit.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs};
        quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
        if (trial[WIDTH]) begin
            rem_nx = rem_sh[WIDTH-1:0];
        end else begin
            rem_nx = trial[WIDTH-1:0];
        end
        last = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            Q     <= '0;
            R     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo <= A;
                        dvs <= B;
                        rem <= '0;
                        cnt <= '0;
                        if (B != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= ZERO;
                        end
                    end
                end
                RUN: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Q     <= quo_nx;
                        R     <= rem_nx;
                        div0  <= 1'b0;
                    end
                end
                ZERO: begin
                    state <= DONE;
                    done  <= 1'b1;
                    Q     <= '1;
                    R     <= quo;
                    div0  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and exhaustive checks of divider (WIDTH = 4) with a
// result scoreboard filled at issue time and drained on each done pulse.
module tb_divider;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         div0;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = W'(a);
            e.z = 1'b1;
        end else begin
            e.q = W'(a / b);
            e.r = W'(a % b);
            e.z = 1'b0;
        end
        sbq.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, ".pending"}, 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, ".Q"}, 32'(Q), 32'(e.q));
            chk({tag, ".R"}, 32'(R), 32'(e.r));
            chk({tag, ".div0"}, 32'(div0), 32'(e.z));
        end
    endtask

    // Called at the negedge after the accepting edge; cyc counts edges since it.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input string tag, input int a, input int b);
        int cyc;
        int bc;
        @(negedge clk);
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        push(a, b);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        chk({tag, ".latency"}, 32'(cyc), (b == 0) ? 1 : W);
        chk({tag, ".busy_cycles"}, 32'(bc), (b == 0) ? 0 : W);
        pop_check(tag);
        @(negedge clk);
        chk({tag, ".done_drop"}, 32'(done), 0);
        chk({tag, ".idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int cyc;
        int bc;
        int pulses;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #3;
        chk("rst.Q", 32'(Q), 0);
        chk("rst.R", 32'(R), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.div0", 32'(div0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("d13_4", 13, 4);
        @(negedge clk);
        @(negedge clk);
        chk("d13_4.hold_Q", 32'(Q), 3);
        chk("d13_4.hold_R", 32'(R), 1);

        do_op("d15_1", 15, 1);
        do_op("d3_9", 3, 9);
        do_op("d0_5", 0, 5);
        do_op("d7_0", 7, 0);
        do_op("d8_2", 8, 2);
        chk("d8_2.div0_clear", 32'(div0), 0);

        // start pulsed during RUN with other operands must be ignored
        @(negedge clk);
        A     = 4'd9;
        B     = 4'd2;
        start = 1'b1;
        push(9, 2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A     = 4'd1;
        B     = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        chk("ign.latency", 32'(cyc), W - 2);
        pop_check("ign");
        pulses = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("ign.pulses", 32'(pulses), 1);

        // start held high: re-accepted on the edge after done drops
        @(negedge clk);
        A     = 4'd6;
        B     = 4'd3;
        start = 1'b1;
        push(6, 3);
        @(negedge clk);
        chk("hold.busy_first", 32'(busy), 1);
        wait_done(cyc, bc);
        chk("hold.latency", 32'(cyc), W);
        pop_check("hold");
        push(6, 3);
        @(negedge clk);
        chk("hold.done_drop", 32'(done), 0);
        chk("hold.idle_gap", 32'(busy), 0);
        @(negedge clk);
        chk("hold.reaccept", 32'(busy), 1);
        start = 1'b0;
        wait_done(cyc, bc);
        chk("hold2.latency", 32'(cyc), W);
        pop_check("hold2");
        @(negedge clk);

        // asynchronous reset in the middle of a 14/3 divide
        @(negedge clk);
        A     = 4'd14;
        B     = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.Q", 32'(Q), 0);
        chk("mrst.R", 32'(R), 0);
        chk("mrst.busy", 32'(busy), 0);
        chk("mrst.done", 32'(done), 0);
        chk("mrst.div0", 32'(div0), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("mrst.no_done", 32'(pulses), 0);
        rst_n = 1'b1;
        do_op("d14_3", 14, 3);

        // every operand pair, with the product identity checked independently
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op($sformatf("ex_%0d_%0d", a, b), a, b);
                if (b != 0) begin
                    chk($sformatf("ex_%0d_%0d.qb_plus_r", a, b), 32'(int'(Q) * b + int'(R)), 32'(a));
                    chk($sformatf("ex_%0d_%0d.r_lt_b", a, b), 32'(int'(R) < b), 1);
                end else begin
                    chk($sformatf("ex_%0d_%0d.div0", a, b), 32'(div0), 1);
                end
            end
        end

        chk("sb.drained", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
